// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: op codes, FSM states, counter width, latencies.
// The multiply-accumulate op codes only start an operation when MDU_MADD_EN is defined.
package mdu_pkg;

    localparam int CNT_W            = 4;
    localparam int DEF_MULT_CYCLES  = 5;
    localparam int DEF_DIV_CYCLES   = 10;

    typedef enum logic [3:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MTHI    = 4'd5,
        MTLO    = 4'd6,
        MADD    = 4'd7,
        MADDU   = 4'd8,
        MSUB    = 4'd9,
        MSUBU   = 4'd10
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    function automatic logic md_is_start(input logic [3:0] op);
        case (op)
            MULT, MULTU, DIV, DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MADD, MADDU, MSUB, MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit result {HI,LO} for mult/div ops, including divide-by-zero and overflow rules.
// Accumulate ops are computed only when MDU_MADD_EN is defined.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] hilo,
    output logic [63:0] result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] b_safe;
    logic [31:0] quo_u;
    logic [31:0] rem_u;

    // Sign-extending to 64 bits makes the low 64 bits of the product exactly the signed result.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign a_mag  = a[31] ? (~a + 32'd1) : a;
    assign b_mag  = b[31] ? (~b + 32'd1) : b;
    assign b_safe = (b == 32'd0) ? 32'd1 : b;

    // Magnitude division; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    assign q_mag  = a_mag / ((b_mag == 32'd0) ? 32'd1 : b_mag);
    assign r_mag  = a_mag % ((b_mag == 32'd0) ? 32'd1 : b_mag);
    assign quo_s  = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    assign rem_s  = a[31] ? (~r_mag + 32'd1) : r_mag;
    assign quo_u  = a / b_safe;
    assign rem_u  = a % b_safe;

    always_comb begin
        result = 64'd0;
        case (op)
            MULT:  result = prod_s;
            MULTU: result = prod_u;
            DIV:   result = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {rem_s, quo_s};
            DIVU:  result = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {rem_u, quo_u};
`ifdef MDU_MADD_EN
            MADD:  result = hilo + prod_s;
            MADDU: result = hilo + prod_u;
            MSUB:  result = hilo - prod_s;
            MSUBU: result = hilo - prod_u;
`endif
            default: result = 64'd0;
        endcase
    end

`ifndef MDU_MADD_EN
    logic unused_hilo;
    assign unused_hilo = ^hilo;
`endif

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit owning HI/LO; fixed-latency FSM with single-cycle mthi/mtlo.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  E_MDOp,
    input  logic        E_MDValid,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_MDStart,
    output logic        E_MDBusy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state;
    logic [CNT_W-1:0] counter;
    logic [31:0]      pending_hi;
    logic [31:0]      pending_lo;
    logic [63:0]      calc_result;

    assign E_MDStart = E_MDValid && md_is_start(E_MDOp);

    mdu_calc u_calc (
        .op     (E_MDOp),
        .a      (E_A),
        .b      (E_B),
        .hilo   ({HI, LO}),
        .result (calc_result)
    );

    // HI/LO cannot change while busy, so an accumulate computed at start equals one computed at commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            counter    <= '0;
            E_MDBusy   <= 1'b0;
            pending_hi <= 32'd0;
            pending_lo <= 32'd0;
            HI         <= 32'd0;
            LO         <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (E_MDStart) begin
                        pending_hi <= calc_result[63:32];
                        pending_lo <= calc_result[31:0];
                        counter    <= md_is_div(E_MDOp) ? DIV_LOAD : MULT_LOAD;
                        E_MDBusy   <= 1'b1;
                        state      <= BUSY;
                    end else if (E_MDValid && (E_MDOp == MTHI)) begin
                        HI <= E_A;
                    end else if (E_MDValid && (E_MDOp == MTLO)) begin
                        LO <= E_A;
                    end
                end
                BUSY: begin
                    if (counter == CNT_W'(1)) begin
                        HI       <= pending_hi;
                        LO       <= pending_lo;
                        counter  <= '0;
                        E_MDBusy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit with hand-computed HI/LO results and busy timing.
// Honours MDU_MADD_EN to pick the accumulate-op expectation.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  E_MDOp;
    logic        E_MDValid;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_MDStart;
    logic        E_MDBusy;
    logic [31:0] HI;
    logic [31:0] LO;

    int vectorCount;
    int missCount;

    mdu_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .E_MDOp    (E_MDOp),
        .E_MDValid (E_MDValid),
        .E_A       (E_A),
        .E_B       (E_B),
        .E_MDStart (E_MDStart),
        .E_MDBusy  (E_MDBusy),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The hazard unit never lets an md op reach EX while busy; the stimulus must respect that too.
    always @(posedge clk) begin
        if (rst_n === 1'b1)
            assert (!(E_MDBusy && E_MDValid &&
                      (E_MDStart || E_MDOp == MTHI || E_MDOp == MTLO)))
                else $error("[TB] md op issued while unit busy");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic valid,
                                 input logic [31:0] a, input logic [31:0] b);
        E_MDOp    = op;
        E_MDValid = valid;
        E_A       = a;
        E_B       = b;
        #1;
    endtask

    task automatic idleInputs();
        E_MDOp    = MD_NONE;
        E_MDValid = 1'b0;
        E_A       = 32'd0;
        E_B       = 32'd0;
    endtask

    task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int cycles,
                         input logic [31:0] expHi, input logic [31:0] expLo);
        applyStimulus(op, 1'b1, a, b);
        checkOutput({tag, ".start"}, 32'(E_MDStart), 32'd1);
        checkOutput({tag, ".busy0"}, 32'(E_MDBusy), 32'd0);
        step();
        idleInputs();
        for (int i = 1; i <= cycles; i++) begin
            checkOutput($sformatf("%s.busy%0d", tag, i), 32'(E_MDBusy), 32'd1);
            step();
        end
        checkOutput({tag, ".busyDone"}, 32'(E_MDBusy), 32'd0);
        checkOutput({tag, ".hi"}, HI, expHi);
        checkOutput({tag, ".lo"}, LO, expLo);
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        rst_n       = 1'b0;
        idleInputs();
        step();
        step();
        checkOutput("reset.hi", HI, 32'd0);
        checkOutput("reset.lo", LO, 32'd0);
        checkOutput("reset.busy", 32'(E_MDBusy), 32'd0);
        rst_n = 1'b1;
        step();

        runOp("mult",  MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        runOp("multu", MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        runOp("multNeg", MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5, 32'd0, 32'd12);
        runOp("div",   DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divuZero", DIVU, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF);
        runOp("divOvf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        runOp("divu",  DIVU,  32'd100, 32'd7, 10, 32'd2, 32'd14);

        // A start with valid low must be a bubble.
        applyStimulus(MULT, 1'b0, 32'd9, 32'd9);
        checkOutput("bubble.start", 32'(E_MDStart), 32'd0);
        step();
        idleInputs();
        checkOutput("bubble.busy", 32'(E_MDBusy), 32'd0);
        checkOutput("bubble.lo", LO, 32'd14);

        applyStimulus(MTHI, 1'b1, 32'h1234_5678, 32'd0);
        checkOutput("mthi.start", 32'(E_MDStart), 32'd0);
        step();
        applyStimulus(MTLO, 1'b1, 32'h9ABC_DEF0, 32'd0);
        checkOutput("mthi.hi", HI, 32'h1234_5678);
        checkOutput("mthi.loKept", LO, 32'd14);
        checkOutput("mthi.busy", 32'(E_MDBusy), 32'd0);
        step();
        idleInputs();
        checkOutput("mtlo.lo", LO, 32'h9ABC_DEF0);
        checkOutput("mtlo.hiKept", HI, 32'h1234_5678);
        checkOutput("mtlo.busy", 32'(E_MDBusy), 32'd0);

        // Reset lands in the third busy cycle of a 4x5 multiply.
        applyStimulus(MULT, 1'b1, 32'd4, 32'd5);
        step();
        idleInputs();
        step();
        step();
        checkOutput("rstMid.busy3", 32'(E_MDBusy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkOutput("rstMid.busy", 32'(E_MDBusy), 32'd0);
        checkOutput("rstMid.hi", HI, 32'd0);
        checkOutput("rstMid.lo", LO, 32'd0);
        step();
        step();
        step();
        checkOutput("rstMid.hiLater", HI, 32'd0);
        checkOutput("rstMid.loLater", LO, 32'd0);
        checkOutput("rstMid.busyLater", 32'(E_MDBusy), 32'd0);

        applyStimulus(MTLO, 1'b1, 32'hFFFF_FFFF, 32'd0);
        step();
        idleInputs();
        checkOutput("maddSetup.lo", LO, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        runOp("maddu", MADDU, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
        applyStimulus(MADDU, 1'b1, 32'd1, 32'd1);
        checkOutput("maddOff.start", 32'(E_MDStart), 32'd0);
        step();
        idleInputs();
        checkOutput("maddOff.busy", 32'(E_MDBusy), 32'd0);
        step();
        checkOutput("maddOff.hi", HI, 32'd0);
        checkOutput("maddOff.lo", LO, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
